// File: rtl/gpu_mem_vramcpu_fifo_nw1r.sv
// Multi-lane write, wide-read pixel FIFO for the VRAM<->CPU path.
// Up to LANES words are pushed per cycle; RD_WORDS words leave as one beat. final_i pads to a whole beat.

module gpu_mem_vramcpu_fifo_nw1r_chk #(
    parameter int ADDR_W   = 4,
    parameter int RD_WORDS = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic [ADDR_W:0]   count_i,
    input logic [ADDR_W:0]   count_next_i,
    input logic              pop_ok_i
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] RD_C    = (ADDR_W+1)'(RD_WORDS);

    // occupancy bounds: never above DEPTH, never popped below one beat
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_next_i <= DEPTH_C) else $error("fifo count above depth");
            assert (!(pop_ok_i && (count_i < RD_C))) else $error("fifo pop underflow");
        end
    end
endmodule

module gpu_mem_vramcpu_fifo_nw1r #(
    parameter int               WIDTH     = 16,
    parameter int               LANES     = 2,
    parameter int               RD_WORDS  = 2,
    parameter int               ADDR_W    = 4,
    parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b0}}
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LANES-1:0]          push_i,
    input  logic [LANES*WIDTH-1:0]    data_in_i,
    input  logic                      final_i,
    input  logic                      flush_i,
    output logic                      accept_o,
    input  logic                      pop_i,
    output logic                      valid_o,
    output logic [RD_WORDS*WIDTH-1:0] data_out_o,
    output logic [ADDR_W:0]           level_o,
    output logic                      err_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam int SLOTS = LANES + RD_WORDS - 1;

    localparam logic [CW-1:0]     DEPTH_C      = CW'(DEPTH);
    localparam logic [CW-1:0]     THRESH_C     = CW'(SLOTS);
    localparam logic [CW-1:0]     RD_C         = CW'(RD_WORDS);
    localparam logic [ADDR_W-1:0] ALIGN_MASK_C = ADDR_W'(RD_WORDS - 1);

    // A legal mask is 0..01..1: adding one to it clears every set bit.
    function automatic logic is_thermo(input logic [LANES-1:0] m);
        return ((m + LANES'(1'b1)) & m) == '0;
    endfunction

    function automatic logic [CW-1:0] ones_count(input logic [LANES-1:0] m);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CW'(m[i]);
        end
        return c;
    endfunction

    logic [WIDTH-1:0]  ram_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              accept_r, valid_r, err_r;

    logic                   legal_s, push_ok_s, final_ok_s, pop_ok_s;
    logic [CW-1:0]          n_s, nwr_s, pad_s, count_next_s;
    logic [ADDR_W-1:0]      phase_s, wr_next_s, rd_next_s;
    logic [SLOTS*WIDTH-1:0] ext_s;
    logic [ADDR_W-1:0]      slot_addr_s [SLOTS];
    logic [WIDTH-1:0]       slot_data_s [SLOTS];
    logic [SLOTS-1:0]       slot_we_s;

    // push/pad/pop qualification and next pointer/count values
    always_comb begin
        legal_s    = is_thermo(push_i);
        n_s        = ones_count(push_i);
        push_ok_s  = accept_r && legal_s && !flush_i;
        nwr_s      = push_ok_s ? n_s : '0;
        final_ok_s = final_i && push_ok_s;
        phase_s    = (wr_ptr_r + nwr_s[ADDR_W-1:0]) & ALIGN_MASK_C;
        if (final_ok_s && (phase_s != '0)) begin
            pad_s = RD_C - CW'(phase_s);
        end else begin
            pad_s = '0;
        end
        pop_ok_s = pop_i && valid_r && !flush_i;
        if (flush_i) begin
            count_next_s = '0;
            wr_next_s    = '0;
            rd_next_s    = '0;
        end else begin
            count_next_s = count_r + nwr_s + pad_s - (pop_ok_s ? RD_C : '0);
            wr_next_s    = wr_ptr_r + nwr_s[ADDR_W-1:0] + pad_s[ADDR_W-1:0];
            rd_next_s    = pop_ok_s ? (rd_ptr_r + RD_C[ADDR_W-1:0]) : rd_ptr_r;
        end
    end

    // per-slot write ports: pushed words first, pad words right after them
    always_comb begin
        ext_s                    = {SLOTS{PAD_VALUE}};
        ext_s[LANES*WIDTH-1:0]   = data_in_i;
        for (int j = 0; j < SLOTS; j++) begin
            slot_addr_s[j] = wr_ptr_r + ADDR_W'(j);
            slot_data_s[j] = (CW'(j) < nwr_s) ? ext_s[j*WIDTH +: WIDTH] : PAD_VALUE;
            slot_we_s[j]   = CW'(j) < (nwr_s + pad_s);
        end
    end

    // storage array, deliberately not reset
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < SLOTS; j++) begin
            if (slot_we_s[j]) begin
                ram_r[slot_addr_s[j]] <= slot_data_s[j];
            end
        end
    end

    // pointers, count, registered status flags and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            accept_r <= 1'b1;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            accept_r <= (DEPTH_C - count_next_s) >= THRESH_C;
            valid_r  <= count_next_s >= RD_C;
            err_r    <= err_r | ~legal_s;
        end
    end

    // beat read straight from the registered read pointer
    always_comb begin
        for (int i = 0; i < RD_WORDS; i++) begin
            data_out_o[i*WIDTH +: WIDTH] = ram_r[rd_ptr_r + ADDR_W'(i)];
        end
    end

    assign accept_o = accept_r;
    assign valid_o  = valid_r;
    assign level_o  = count_r;
    assign err_o    = err_r;

    gpu_mem_vramcpu_fifo_nw1r_chk #(
        .ADDR_W   (ADDR_W),
        .RD_WORDS (RD_WORDS)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .count_i      (count_r),
        .count_next_i (count_next_s),
        .pop_ok_i     (pop_ok_s)
    );
endmodule

// File: tb/tb_gpu_mem_vramcpu_fifo_nw1r.sv
// Directed + short random bench for the multi-lane FIFO with a word-queue scoreboard.

module tb_gpu_mem_vramcpu_fifo_nw1r;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  push_i = 2'b00;
    logic [31:0] data_in_i = 32'h0;
    logic        final_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        accept_o;
    logic        pop_i = 1'b0;
    logic        valid_o;
    logic [31:0] data_out_o;
    logic [3:0]  level_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    logic [15:0] q[$];
    int          cnt_m = 0;
    int          wr_m  = 0;
    bit          err_m = 1'b0;

    always #5 clk_i = ~clk_i;

    gpu_mem_vramcpu_fifo_nw1r #(
        .WIDTH     (16),
        .LANES     (2),
        .RD_WORDS  (2),
        .ADDR_W    (3),
        .PAD_VALUE (16'h0000)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_i),
        .data_in_i  (data_in_i),
        .final_i    (final_i),
        .flush_i    (flush_i),
        .accept_o   (accept_o),
        .pop_i      (pop_i),
        .valid_o    (valid_o),
        .data_out_o (data_out_o),
        .level_o    (level_o),
        .err_o      (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_level"},  {28'h0, level_o}, cnt_m);
        chk({tag, "_valid"},  {31'h0, valid_o}, (cnt_m >= 2) ? 32'd1 : 32'd0);
        chk({tag, "_accept"}, {31'h0, accept_o}, ((8 - cnt_m) >= 3) ? 32'd1 : 32'd0);
        chk({tag, "_err"},    {31'h0, err_o}, {31'h0, err_m});
    endtask

    task automatic do_reset();
        rst_i = 1'b1; push_i = 2'b00; final_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        q.delete(); cnt_m = 0; wr_m = 0; err_m = 1'b0;
        chk_status("reset");
    endtask

    task automatic step(input logic [1:0] p, input logic [31:0] d, input logic fin,
                        input logic pop, input logic fl);
        bit acc;
        bit legal;
        int n;
        push_i = p; data_in_i = d; final_i = fin; pop_i = pop; flush_i = fl;
        acc   = (8 - cnt_m) >= 3;
        legal = (p != 2'b10);
        n     = (p == 2'b11) ? 2 : ((p == 2'b01) ? 1 : 0);
        if (!legal) err_m = 1'b1;
        if (fl) begin
            q.delete(); cnt_m = 0; wr_m = 0;
        end else begin
            if (pop && cnt_m >= 2) begin
                chk("pop_data", data_out_o, {q[1], q[0]});
                void'(q.pop_front());
                void'(q.pop_front());
                cnt_m -= 2;
            end
            if (legal && acc) begin
                if (n >= 1) q.push_back(d[15:0]);
                if (n == 2) q.push_back(d[31:16]);
                cnt_m += n; wr_m += n;
                if (fin && (wr_m % 2) != 0) begin
                    q.push_back(16'h0000);
                    cnt_m += 1; wr_m += 1;
                end
            end
        end
        @(posedge clk_i); #1;
        push_i = 2'b00; final_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
        chk_status("step");
    endtask

    initial begin
        do_reset();
        // pop on empty is ignored
        step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // basic two-lane push then pop
        step(2'b11, 32'h2222_1111, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // single word with final is padded
        step(2'b01, 32'h0000_AAAA, 1'b1, 1'b0, 1'b0);
        chk("pad_beat", data_out_o, 32'h0000_AAAA);
        step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // final alone on an aligned stream
        step(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        step(2'b11, 32'h4444_3333, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        // odd word then a standalone final pads it
        step(2'b01, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        // fill until accept drops, further pushes ignored
        step(2'b11, 32'h7777_6666, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h9999_8888, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'hBBBB_AAAA, 1'b0, 1'b0, 1'b0);
        // push+pop at full: push refused, pop proceeds
        step(2'b11, 32'hDDDD_CCCC, 1'b0, 1'b1, 1'b0);
        // steady push+pop across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(2'b11, {16'(16'h1000 + 2*i + 1), 16'(16'h1000 + 2*i)}, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // illegal mask sets a sticky error, nothing written, final ignored
        step(2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        step(2'b01, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
        step(2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        step(2'b01, 32'h0000_0456, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // flush overrides push and pop
        step(2'b11, 32'hEEEE_FFFF, 1'b0, 1'b0, 1'b0);
        step(2'b11, 32'h1212_3434, 1'b1, 1'b1, 1'b1);
        step(2'b11, 32'h5656_7878, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // reset mid-stream drops a pending partial beat and clears err
        step(2'b01, 32'h0000_9A9A, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(2'b11, 32'hBCBC_ABAB, 1'b0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        // short random mix of legal traffic
        for (int i = 0; i < 60; i++) begin
            logic [1:0] p;
            int sel;
            sel = $urandom_range(0, 2);
            p = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b11);
            step(p, $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 19) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
